// File: rtl/ps2_command_tx.sv
// Host-to-device PS/2 command transmitter: clock inhibit, request-to-send,
// 11-bit frame shift-out on device clock falls, ACK check and timeouts.
module ps2_command_tx #(
   parameter int unsigned INHIBIT_CYCLES = 5000,
   parameter int unsigned START_TIMEOUT  = 750000,
   parameter int unsigned BIT_TIMEOUT    = 100000,
   parameter int unsigned IDLE_TIMEOUT   = 100000
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [7:0] cmd_data,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe,
   output logic       busy,
   output logic       cmd_sent,
   output logic       ack_err,
   output logic       timeout_err
);

   localparam int unsigned MAX_A   = (INHIBIT_CYCLES > START_TIMEOUT) ? INHIBIT_CYCLES : START_TIMEOUT;
   localparam int unsigned MAX_B   = (BIT_TIMEOUT > IDLE_TIMEOUT) ? BIT_TIMEOUT : IDLE_TIMEOUT;
   localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INHIBIT,
      S_RELEASE,
      S_SHIFT,
      S_ACK,
      S_WAIT_IDLE
   } state_e;

   state_e             state_q, state_d;
   logic [9:0]         frame_q, frame_d;
   logic [3:0]         bit_cnt_q, bit_cnt_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               clk_s1_q, clk_s2_q, clk_prev_q;
   logic               dat_s1_q, dat_s2_q;
   logic               clk_oe_q, clk_oe_d;
   logic               dat_oe_q, dat_oe_d;
   logic               ready_q, ready_d;
   logic               busy_q, busy_d;
   logic               sent_q, sent_d;
   logic               ack_err_q, ack_err_d;
   logic               to_err_q, to_err_d;
   logic               fall;
   logic               expire;
   logic               tick;

   assign fall   = clk_prev_q & ~clk_s2_q;
   assign expire = (cnt_q <= CNT_W'(1));

   // State, synchronisers and registered outputs
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q    <= S_IDLE;
         frame_q    <= '0;
         bit_cnt_q  <= '0;
         cnt_q      <= '0;
         clk_s1_q   <= 1'b1;
         clk_s2_q   <= 1'b1;
         clk_prev_q <= 1'b1;
         dat_s1_q   <= 1'b1;
         dat_s2_q   <= 1'b1;
         clk_oe_q   <= 1'b0;
         dat_oe_q   <= 1'b0;
         ready_q    <= 1'b1;
         busy_q     <= 1'b0;
         sent_q     <= 1'b0;
         ack_err_q  <= 1'b0;
         to_err_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         frame_q    <= frame_d;
         bit_cnt_q  <= bit_cnt_d;
         cnt_q      <= cnt_d;
         clk_s1_q   <= ps2_clk_in;
         clk_s2_q   <= clk_s1_q;
         clk_prev_q <= clk_s2_q;
         dat_s1_q   <= ps2_dat_in;
         dat_s2_q   <= dat_s1_q;
         clk_oe_q   <= clk_oe_d;
         dat_oe_q   <= dat_oe_d;
         ready_q    <= ready_d;
         busy_q     <= busy_d;
         sent_q     <= sent_d;
         ack_err_q  <= ack_err_d;
         to_err_q   <= to_err_d;
      end
   end

   // Next-state and next-output logic; tick marks cycles where the timeout runs
   always_comb begin
      state_d   = state_q;
      frame_d   = frame_q;
      bit_cnt_d = bit_cnt_q;
      cnt_d     = cnt_q;
      clk_oe_d  = clk_oe_q;
      dat_oe_d  = dat_oe_q;
      sent_d    = 1'b0;
      ack_err_d = 1'b0;
      to_err_d  = 1'b0;
      tick      = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            if (cmd_valid && ready_q) begin
               frame_d  = {1'b1, ~^cmd_data, cmd_data};
               cnt_d    = CNT_W'(INHIBIT_CYCLES - 1);
               clk_oe_d = 1'b1;
               dat_oe_d = (INHIBIT_CYCLES == 1);
               state_d  = S_INHIBIT;
            end
         end
         S_INHIBIT: begin
            if (cnt_q == '0) begin
               clk_oe_d  = 1'b0;
               dat_oe_d  = 1'b1;
               bit_cnt_d = '0;
               cnt_d     = CNT_W'(START_TIMEOUT);
               state_d   = S_RELEASE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
               // start bit appears on the final inhibit cycle
               if (cnt_q == CNT_W'(1)) dat_oe_d = 1'b1;
            end
         end
         S_RELEASE: state_d = S_SHIFT;
         S_SHIFT: begin
            if (fall) begin
               dat_oe_d  = ~frame_q[0];
               frame_d   = {1'b0, frame_q[9:1]};
               bit_cnt_d = bit_cnt_q + 4'd1;
               cnt_d     = CNT_W'(BIT_TIMEOUT);
               if (bit_cnt_q == 4'd9) state_d = S_ACK;
            end else begin
               tick = 1'b1;
            end
         end
         S_ACK: begin
            if (fall) begin
               dat_oe_d = 1'b0;
               if (!dat_s2_q) begin
                  cnt_d   = CNT_W'(IDLE_TIMEOUT);
                  state_d = S_WAIT_IDLE;
               end else begin
                  ack_err_d = 1'b1;
                  state_d   = S_IDLE;
               end
            end else begin
               tick = 1'b1;
            end
         end
         S_WAIT_IDLE: begin
            if (clk_s2_q && dat_s2_q) begin
               sent_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               tick = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (tick) begin
         if (expire) begin
            to_err_d = 1'b1;
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            state_d  = S_IDLE;
         end else begin
            cnt_d = cnt_q - CNT_W'(1);
         end
      end

      ready_d = (state_d == S_IDLE);
      busy_d  = (state_d != S_IDLE);
   end

   assign cmd_ready   = ready_q;
   assign busy        = busy_q;
   assign ps2_clk_oe  = clk_oe_q;
   assign ps2_dat_oe  = dat_oe_q;
   assign cmd_sent    = sent_q;
   assign ack_err     = ack_err_q;
   assign timeout_err = to_err_q;

endmodule
